// File: rtl/key_matrix_scan_if.sv
// Key-matrix scanner signal bundle: matrix row/column lines, scan enable and the
// decoded key event outputs. The slave modport is the scanner, the master its environment.
interface key_matrix_scan_if;
  logic       scan_en;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output scan_en, key_col,
    input  key_row, key_code, key_valid, key_held
  );

  modport slave (
    input  scan_en, key_col,
    output key_row, key_code, key_valid, key_held
  );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner with frame-based press/release debounce.
// Optional auto-repeat of the held key is enabled by defining KEY_REPEAT_EN.
module key_matrix_scan #(
  parameter int ROW_CYCLES        = 50000,
  parameter int DEB_FRAMES        = 5,
  parameter int REP_DELAY_FRAMES  = 125,
  parameter int REP_PERIOD_FRAMES = 25
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  key_matrix_scan_if.slave kp
);

  localparam int SLOT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int DEB_W  = $clog2(DEB_FRAMES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(ROW_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_FRAMES);

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REP_DELAY_FRAMES > REP_PERIOD_FRAMES) ? REP_DELAY_FRAMES
                                                                   : REP_PERIOD_FRAMES;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REP_DELAY_FRAMES);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REP_PERIOD_FRAMES);
  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_first_q;
`else
  logic unused_rep_params;
  assign unused_rep_params = (REP_DELAY_FRAMES > 0) ^ (REP_PERIOD_FRAMES > 0);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED} state_e;

  logic [3:0] col_meta_q, col_sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      // NOTE: non-blocking so the second stage takes the first stage's pre-edge value;
      // blocking assignments here would collapse the synchronizer into one flop.
      col_meta_q <= kp.key_col;
      col_sync_q <= col_meta_q;
    end
  end

  logic [1:0]        row_idx_q, row_idx_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [3:0]        key_row_q, key_row_d;
  logic              scanning, slot_end;

  // A released row bus means the scanner is stopped, so no separate run flag is kept.
  assign scanning = (key_row_q != 4'b1111);
  assign slot_end = scanning && (slot_cnt_q == SLOT_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    row_idx_d  = row_idx_q;
    slot_cnt_d = slot_cnt_q;
    key_row_d  = key_row_q;
    if (!kp.scan_en) begin
      row_idx_d  = '0;
      slot_cnt_d = '0;
      key_row_d  = 4'b1111;
    end else if (!scanning) begin
      row_idx_d  = '0;
      slot_cnt_d = '0;
      key_row_d  = 4'b1110;
    end else if (slot_end) begin
      row_idx_d  = row_idx_q + 2'd1;
      slot_cnt_d = '0;
      key_row_d  = ~(4'b0001 << row_idx_d);
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
    end
  end

  logic [15:0] frame_q;
  logic        frame_rdy_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_idx_q   <= '0;
      slot_cnt_q  <= '0;
      key_row_q   <= 4'b1111;
      frame_q     <= '0;
      frame_rdy_q <= 1'b0;
    end else begin
      row_idx_q   <= row_idx_d;
      slot_cnt_q  <= slot_cnt_d;
      key_row_q   <= key_row_d;
      frame_rdy_q <= kp.scan_en && slot_end && (row_idx_q == 2'd3);
      // Bit {row, col} is set when that key reads closed, so a set bit index is its code.
      if (slot_end) frame_q[{row_idx_q, 2'b00} +: 4] <= ~col_sync_q;
    end
  end

  logic       frame_none, frame_single, hit;
  logic [3:0] frame_code;

  assign frame_none   = (frame_q == '0);
  assign frame_single = !frame_none && ((frame_q & (frame_q - 16'd1)) == '0);

  always_comb begin
    frame_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) frame_code = 4'(i);
    end
  end

  state_e           state_q;
  logic [3:0]       cand_q, code_q;
  logic [DEB_W-1:0] cnt_q;
  logic             valid_q, held_q;

  assign hit = frame_single && (frame_code == cand_q);

  // cnt_q counts matching frames in DEBOUNCE and non-matching frames in PRESSED.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      valid_q <= 1'b0;
      if (!kp.scan_en) begin
        state_q <= ST_IDLE;
        held_q  <= 1'b0;
        cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
`endif
      end else if (frame_rdy_q) begin
        unique case (state_q)
          ST_IDLE: begin
            if (frame_single) begin
              cand_q <= frame_code;
              if (DEB_FRAMES == 1) begin
                code_q  <= frame_code;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                cnt_q   <= '0;
                state_q <= ST_PRESSED;
              end else begin
                cnt_q   <= DEB_W'(1);
                state_q <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (hit) begin
              if (cnt_q + 1'b1 == DEB_LAST) begin
                code_q  <= cand_q;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                cnt_q   <= '0;
                state_q <= ST_PRESSED;
`ifdef KEY_REPEAT_EN
                rep_cnt_q   <= '0;
                rep_first_q <= 1'b1;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else if (frame_single) begin
              cand_q <= frame_code;
              cnt_q  <= DEB_W'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (hit) begin
              cnt_q <= '0;
`ifdef KEY_REPEAT_EN
              if (rep_cnt_q + 1'b1 == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                valid_q     <= 1'b1;
                rep_cnt_q   <= '0;
                rep_first_q <= 1'b0;
              end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
              end
`endif
            end else begin
`ifdef KEY_REPEAT_EN
              rep_cnt_q   <= '0;
              rep_first_q <= 1'b1;
`endif
              if (cnt_q + 1'b1 == DEB_LAST) begin
                held_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign kp.key_row   = key_row_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan: a frame-level press/release model predicts
// every output each cycle while directed and random key patterns are applied.
module tb_key_matrix_scan;
  localparam int ROW_CYCLES = 4;
  localparam int DEB_FRAMES = 3;
  localparam int REP_DELAY  = 4;
  localparam int REP_PERIOD = 2;
  localparam int FRAME      = 4 * ROW_CYCLES;
`ifdef KEY_REPEAT_EN
  localparam int HOLD_PULSES = 3;
`else
  localparam int HOLD_PULSES = 1;
`endif

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] keys      = '0;

  key_matrix_scan_if ifc ();

  key_matrix_scan #(
    .ROW_CYCLES       (ROW_CYCLES),
    .DEB_FRAMES       (DEB_FRAMES),
    .REP_DELAY_FRAMES (REP_DELAY),
    .REP_PERIOD_FRAMES(REP_PERIOD)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .kp       (ifc.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Passive matrix: a closed key pulls its column low while its row is driven low.
  function automatic logic [3:0] matrix_cols(input logic [3:0] rows, input logic [15:0] k);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (!rows[r] && k[r*4+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign ifc.key_col = matrix_cols(ifc.key_row, keys);

  int          n_pass = 0;
  int          n_checks = 0;
  int          pulses = 0;
  bit          scanning;
  int          p;
  logic [15:0] fm [0:255];
  logic [3:0]  exp_row, exp_code, streak_key;
  logic        exp_valid, exp_held;
  int          streak_len, miss_len, rep_cnt;
  bit          rep_first;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    check("key_row",   {4'h0, ifc.key_row},  {4'h0, exp_row});
    check("key_code",  {4'h0, ifc.key_code}, {4'h0, exp_code});
    check("key_valid", {7'h0, ifc.key_valid}, {7'h0, exp_valid});
    check("key_held",  {7'h0, ifc.key_held},  {7'h0, exp_held});
  endtask

  task automatic model_reset();
    exp_row = 4'hF; exp_code = 4'h0; exp_valid = 1'b0; exp_held = 1'b0;
    scanning = 1'b0; p = 0; streak_len = 0; miss_len = 0; rep_cnt = 0; rep_first = 1'b1;
  endtask

  // One finished frame: count closed keys and apply the press/release debounce rules.
  task automatic model_frame(input logic [15:0] mask);
    logic [3:0] c;
    bit         single;
    c = 4'h0;
    for (int i = 0; i < 16; i++) if (mask[i]) c = 4'(i);
    single = ($countones(mask) == 1);
    if (!exp_held) begin
      if (single && streak_len > 0 && c == streak_key) streak_len++;
      else if (single) begin streak_key = c; streak_len = 1; end
      else streak_len = 0;
      if (streak_len == DEB_FRAMES) begin
        exp_valid = 1'b1; exp_held = 1'b1; exp_code = c;
        miss_len = 0; streak_len = 0; rep_cnt = 0; rep_first = 1'b1;
      end
    end else if (single && c == exp_code) begin
      miss_len = 0;
`ifdef KEY_REPEAT_EN
      rep_cnt++;
      if (rep_cnt == (rep_first ? REP_DELAY : REP_PERIOD)) begin
        exp_valid = 1'b1; rep_cnt = 0; rep_first = 1'b0;
      end
`endif
    end else begin
      miss_len++; rep_cnt = 0; rep_first = 1'b1;
      if (miss_len == DEB_FRAMES) begin exp_held = 1'b0; streak_len = 0; end
    end
  endtask

  // p counts cycles since the first row-0 cycle; frame f is judged in cycle 16f+16
  // and its effect is visible from cycle 16f+17.
  task automatic tick();
    @(posedge sys_clk);
    exp_valid = 1'b0;
    if (!ifc.scan_en) begin
      exp_row = 4'hF; scanning = 1'b0; p = 0; exp_held = 1'b0;
      streak_len = 0; miss_len = 0; rep_cnt = 0; rep_first = 1'b1;
    end else begin
      if (!scanning) begin scanning = 1'b1; p = 0; end
      else p++;
      exp_row = ~(4'b0001 << ((p / ROW_CYCLES) % 4));
      if (p % FRAME == 0) fm[(p / FRAME) % 256] = keys;
      if (p >= FRAME + 1 && p % FRAME == 1) model_frame(fm[((p - FRAME - 1) / FRAME) % 256]);
    end
    #1;
    check_outputs();
    if (ifc.key_valid === 1'b1) pulses++;
  endtask

  task automatic run_frame(input logic [15:0] mask);
    keys = mask;
    fm[(p / FRAME) % 256] = mask;
    repeat (FRAME) tick();
  endtask

  // Called 1 time unit after a rising edge: reset lands mid-cycle, away from both edges.
  task automatic apply_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int          r, a, b;
    logic [3:0]  cur;
    logic [15:0] mask;
    logic [15:0] one;
    one = 16'h0001;
    ifc.scan_en = 1'b1;
    model_reset();
    #23;
    check_outputs();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    repeat (2) run_frame(16'h0000);

    // Key row2/col1 held for 10 frames, then released.
    pulses = 0;
    repeat (10) run_frame(16'h0200);
    repeat (5) run_frame(16'h0000);
    check("hold_pulses", 8'(pulses), 8'(HOLD_PULSES));

    // Bounce: 2 frames pressed, 1 released, five times.
    pulses = 0;
    repeat (5) begin
      repeat (2) run_frame(16'h0040);
      run_frame(16'h0000);
    end
    repeat (2) run_frame(16'h0000);
    check("bounce_pulses", 8'(pulses), 8'd0);

    // Keys 0 and 5 together: every frame is MULTI.
    pulses = 0;
    repeat (8) run_frame(16'h0021);
    check("multi_pulses", 8'(pulses), 8'd0);
    check("multi_code", {4'h0, ifc.key_code}, 8'h09);
    run_frame(16'h0000);

    // Drop scan_en while key 0xC is held, then re-enable with the key still down.
    repeat (4) run_frame(16'h1000);
    check("held_before_drop", {7'h0, ifc.key_held}, 8'h01);
    repeat (5) tick();
    ifc.scan_en = 1'b0;
    tick();
    check("drop_row", {4'h0, ifc.key_row}, 8'h0F);
    check("drop_held", {7'h0, ifc.key_held}, 8'h00);
    repeat (6) tick();
    pulses = 0;
    ifc.scan_en = 1'b1;
    tick();
    repeat (4) run_frame(16'h1000);
    check("reenable_pulses", 8'(pulses), 8'd1);
    repeat (4) run_frame(16'h0000);

    // Asynchronous reset in the middle of debouncing key 7.
    repeat (2) run_frame(16'h0080);
    repeat (3) tick();
    apply_reset();
    keys = '0;
    tick();

    // Asynchronous reset during the key_valid cycle itself.
    repeat (3) run_frame(16'h0004);
    tick();
    check("valid_before_reset", {7'h0, ifc.key_valid}, 8'h01);
    apply_reset();
    keys = '0;
    tick();

`ifdef KEY_REPEAT_EN
    run_frame(16'h0000);
    pulses = 0;
    repeat (12) run_frame(16'h0008);
    check("repeat_pulses", 8'(pulses), 8'd4);
    repeat (4) run_frame(16'h0000);
`endif

    // Random mix of sustained presses, key changes, releases and multi-key frames.
    cur = 4'($urandom_range(0, 15));
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r <= 5) mask = one << cur;
      else if (r == 6) begin
        cur  = 4'($urandom_range(0, 15));
        mask = one << cur;
      end else if (r == 8) begin
        a    = $urandom_range(0, 15);
        b    = (a + 1 + $urandom_range(0, 14)) % 16;
        mask = (one << a) | (one << b);
      end else mask = 16'h0000;
      run_frame(mask);
    end
    repeat (4) run_frame(16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
